data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Responder side of the data-memory access path. The 2:1 address mux selects the
//   source/destination register on the core side. This block accepts one load or store
//   request at a time over a valid/ready handshake. It performs the access on a
//   2**AW x DW memory and returns a one-cycle response after a fixed latency.
//   It replaces the combinational data memory, so memory latency becomes a modelled
//   multi-cycle stall.
// PARAMETERS
//   DW      8   data width in bits
//   AW      8   address width; memory depth = 2**AW entries
//   RD_LAT  2   cycles from request acceptance to RspValid; legal range 1..15
// PORTS
//   Clk       in   1    clock; all state changes on rising edge
//   Reset     in   1    synchronous, active-high reset
//   ReqValid  in   1    core presents a request this cycle
//   ReqReady  out  1    responder can accept a request this cycle
//   ReqWrite  in   1    1 = store, 0 = load; sampled at acceptance
//   ReqAddr   in   AW   word address (output of the address mux); sampled at acceptance
//   ReqWData  in   DW   store data; sampled at acceptance
//   RspValid  out  1    single-cycle response strobe
//   RspData   out  DW   load data, or echo of the stored data for a store
// BEHAVIOUR
//   Acceptance
//     - A request is accepted on a rising edge where ReqValid && ReqReady.
//     - Request inputs are ignored in all other cycles.
//   States: IDLE, WAIT, RESP
//     - ReqReady = (state==IDLE) || (state==RESP); it is combinational from state only.
//     - IDLE: on accept, go to RESP if RD_LAT==1, else go to WAIT with cnt=RD_LAT-2.
//     - WAIT: if cnt==0, go to RESP; else decrement cnt.
//     - RESP: RspValid=1 for exactly this cycle.
//       Accept in RESP re-enters WAIT or RESP exactly as from IDLE; otherwise go to IDLE.
//   Latency and throughput
//     - Accept at edge E gives RspValid high in the cycle after edge E+RD_LAT-1.
//       That is RD_LAT cycles after the acceptance cycle.
//     - Back-to-back requests give one response every RD_LAT cycles.
//     - There is no response backpressure; the core must take RspData while RspValid=1.
//   Store
//     - mem[ReqAddr] <= ReqWData at the acceptance edge.
//     - RspData = stored data in the RESP cycle.
//   Load
//     - Address is latched at acceptance.
//     - RspData = mem[addr] read at the RESP transition.
//   Ordering
//     - A load accepted after a store to the same address returns the new data.
//     - A store accepted in the RESP cycle of a load does not change that load's RspData.
//   Outside RESP: RspData holds its last value; it is 0 after reset.
//   Reset
//     - Values: state=IDLE, cnt=0, RspValid=0, RspData=0; ReqReady=1 in the first cycle after reset.
//     - Mid-operation reset discards the in-flight request; no RspValid is produced for it.
//     - A store accepted before reset remains in memory.
//     - Memory contents are not cleared by Reset.
//     - If Reset and ReqValid are high on the same edge, Reset wins and nothing is accepted.
// TESTING
//   1. Reset, then store 0xA5 to addr 0x10 -> ReqReady=0 for RD_LAT-1 cycles; RspValid=1 once with RspData=0xA5.
//   2. Load addr 0x10 right after test 1's RESP cycle -> RspData=0xA5 exactly RD_LAT cycles after accept.
//   3. ReqValid held high across 4 loads (addrs 0x00..0x03 preloaded 0x11..0x44)
//      -> 4 responses, spaced RD_LAT cycles, in order 0x11,0x22,0x33,0x44.
//   4. Assert Reset during WAIT of a load -> no RspValid, RspData=0, ReqReady=1 the next cycle;
//      a later load still returns prior memory contents.
//   5. Store 0x3C to 0xFF, then load 0xFF in its RESP cycle -> load returns 0x3C (address wrap-edge, RAW ordering).
//   6. Sweep RD_LAT=1 and RD_LAT=4 builds -> RspValid latency 1 and 4 respectively; at RD_LAT=1, ReqReady stays 1 under continuous requests.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core-side address mux and the data-memory responder.
// The core drives the request fields; the responder drives ready and the response.
interface data_mem_responder_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store over valid/ready,
// then returns a one-cycle response RD_LAT cycles after the acceptance cycle.
module data_mem_responder #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] rsp_data_q;
  logic [DW-1:0] mem [2**AW];
  logic          accept;

  assign bus.req_ready = (state == IDLE) || (state == RESP);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // Request stage: store lands at the acceptance edge unless reset overrides it
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.req_write)
      mem[bus.req_addr] <= bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (accept)
      addr_p0 <= bus.req_addr;
  end

  // Response stage: data is captured on the transition into RESP and held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (RD_LAT == 1) begin
              // Memory write is not visible until after this edge, so echo store data directly
              state      <= RESP;
              rsp_data_q <= bus.req_write ? bus.req_wdata : mem[bus.req_addr];
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            rsp_data_q <= mem[addr_p0];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
